// File: rtl/xm_pkg.sv
// Shared types, default moduli and configuration helpers for the iterative
// constant multiplier xm_iter.
package xm_pkg;

    // Control states of the limb-serial multiplier.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } xm_state_e;

    // Default moduli selected by mode=0 / mode=1.
    localparam logic [191:0] XM_MOD0 =
        192'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFFFF_FFFFFFFF;
    localparam logic [191:0] XM_MOD1 =
        192'hFFFFFFFF_FFFFFFFF_FFFFFFFF_99DEF836_146BC9B1_B4D22831;

    // Number of limbs the operand is split into.
    function automatic int unsigned xm_nlimb(input int unsigned q_w,
                                             input int unsigned limb_w);
        return q_w / limb_w;
    endfunction

    // Width of the exact product q x MOD.
    function automatic int unsigned xm_r_w(input int unsigned q_w,
                                           input int unsigned c_w);
        return q_w + c_w;
    endfunction

    // Operand must split into a whole, non-zero number of limbs.
    function automatic bit xm_cfg_ok(input int unsigned q_w,
                                     input int unsigned limb_w);
        return (limb_w != 0) && (q_w >= limb_w) && ((q_w % limb_w) == 0);
    endfunction

endpackage

// File: rtl/xm_limb_mac.sv
// One limb step of the constant multiply: acc_nxt_c = (acc << LIMB_W) + limb * cval.
// Purely combinational; this is the only multiplier in the design, so it is
// where the LIMB_W x C_W DSP mapping lands.
// Ports:
//   acc       - running accumulator (R_W)
//   limb      - current operand limb, MSB-first (LIMB_W)
//   cval      - selected modulus constant (C_W)
//   acc_nxt_c - accumulator after this limb (R_W)
module xm_limb_mac #(
    parameter int unsigned LIMB_W = 16,
    parameter int unsigned C_W    = 192,
    parameter int unsigned R_W    = 256
) (
    input  logic [R_W-1:0]    acc,
    input  logic [LIMB_W-1:0] limb,
    input  logic [C_W-1:0]    cval,
    output logic [R_W-1:0]    acc_nxt_c
);

    localparam int unsigned P_W = LIMB_W + C_W;

    logic [P_W-1:0] prod;

    // Full-width partial product; never exceeds LIMB_W+C_W bits.
    assign prod = P_W'(limb) * P_W'(cval);

    // Horner step; the exact product fits R_W, so the shift drops only zeros.
    assign acc_nxt_c = (acc << LIMB_W) + R_W'(prod);

endmodule

// File: rtl/xm_iter.sv
// Iterative constant multiplier: out_r = in_q * MOD[in_mode], one LIMB_W limb
// of the operand per cycle, MSB first. Valid/ready on both sides, tag passthrough.
// Ports:
//   clk, rst_n            - clock, asynchronous active-low reset
//   flush                 - synchronous abort back to IDLE (highest priority)
//   in_valid/in_ready     - operand handshake; in_q, in_mode, in_tag payload
//   out_valid/out_ready   - result handshake; out_r, out_tag payload
// in_ready is combinational (depends on out_ready in DONE and on flush).
module xm_iter
    import xm_pkg::*;
#(
    parameter int unsigned     Q_W    = 64,
    parameter int unsigned     LIMB_W = 16,
    parameter int unsigned     C_W    = 192,
    parameter logic [C_W-1:0]  MOD0   = C_W'(XM_MOD0),
    parameter logic [C_W-1:0]  MOD1   = C_W'(XM_MOD1),
    parameter int unsigned     TAG_W  = 8,
    localparam int unsigned    R_W    = xm_r_w(Q_W, C_W)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [Q_W-1:0]   in_q,
    input  logic             in_mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [R_W-1:0]   out_r,
    output logic [TAG_W-1:0] out_tag
);

    localparam int unsigned NLIMB = xm_nlimb(Q_W, LIMB_W);
    localparam int unsigned CNT_W = (NLIMB > 1) ? $clog2(NLIMB) : 1;

    // Reject operand widths that do not split into whole limbs.
    if (!xm_cfg_ok(Q_W, LIMB_W)) begin : g_cfg_err
        $error("xm_iter: Q_W must be a non-zero multiple of LIMB_W");
    end

    xm_state_e state;
    xm_state_e state_nxt;

    logic accept;
    logic step;
    logic finish;
    logic pop;

    logic [Q_W-1:0]    q_reg;
    logic              mode_reg;
    logic [TAG_W-1:0]  tag_reg;
    logic [R_W-1:0]    acc;
    logic [R_W-1:0]    acc_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [LIMB_W-1:0] limb;
    logic [C_W-1:0]    cval;
    logic              last_limb;

    // q_reg shifts left each step, so its top limb is always the current one.
    assign limb      = q_reg[Q_W-1 -: LIMB_W];
    assign cval      = mode_reg ? MOD1 : MOD0;
    assign last_limb = (cnt == CNT_W'(NLIMB - 1));

    xm_limb_mac #(
        .LIMB_W (LIMB_W),
        .C_W    (C_W),
        .R_W    (R_W)
    ) u_mac (
        .acc       (acc),
        .limb      (limb),
        .cval      (cval),
        .acc_nxt_c (acc_nxt)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, handshake and datapath strobes.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        accept    = 1'b0;
        step      = 1'b0;
        finish    = 1'b0;
        pop       = 1'b0;

        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept    = 1'b1;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                step = 1'b1;
                if (last_limb) begin
                    finish    = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                // A result leaving frees the slot for a same-cycle accept.
                in_ready = out_ready;
                if (out_ready) begin
                    pop = 1'b1;
                    if (in_valid) begin
                        accept    = 1'b1;
                        state_nxt = BUSY;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Flush overrides everything, including a pending accept.
        if (flush) begin
            state_nxt = IDLE;
            in_ready  = 1'b0;
            accept    = 1'b0;
            step      = 1'b0;
            finish    = 1'b0;
            pop       = 1'b0;
        end
    end

    // Operand, accumulator and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_reg     <= '0;
            mode_reg  <= 1'b0;
            tag_reg   <= '0;
            acc       <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_r     <= '0;
            out_tag   <= '0;
        end else begin
            if (accept) begin
                q_reg    <= in_q;
                mode_reg <= in_mode;
                tag_reg  <= in_tag;
                acc      <= '0;
                cnt      <= '0;
            end else if (step) begin
                q_reg <= q_reg << LIMB_W;
                acc   <= acc_nxt;
                cnt   <= cnt + CNT_W'(1);
            end

            if (finish) begin
                out_valid <= 1'b1;
                out_r     <= acc_nxt;
                out_tag   <= tag_reg;
            end else if (pop || flush) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_xm_iter.sv
// Scoreboard bench for xm_iter: stimulus pushes expected (product, tag) pairs,
// an independent monitor pops and compares on every output handshake.
module tb_xm_iter;

    localparam logic [191:0] MOD0 =
        192'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFFFF_FFFFFFFF;
    localparam logic [191:0] MOD1 =
        192'hFFFFFFFF_FFFFFFFF_FFFFFFFF_99DEF836_146BC9B1_B4D22831;

    typedef struct packed {
        logic [255:0] r;
        logic [7:0]   tag;
    } exp_t;

    logic         clk       = 1'b0;
    logic         rst_n     = 1'b0;
    logic         flush     = 1'b0;
    logic         in_valid  = 1'b0;
    logic         in_ready;
    logic [63:0]  in_q      = '0;
    logic         in_mode   = 1'b0;
    logic [7:0]   in_tag    = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [255:0] out_r;
    logic [7:0]   out_tag;

    logic ready_dir = 1'b0;
    bit   rand_rdy  = 1'b0;

    int checks = 0;
    int errors = 0;
    int pushed = 0;
    int popped = 0;
    int cyc    = 0;

    exp_t sb[$];

    xm_iter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_q      (in_q),
        .in_mode   (in_mode),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_r     (out_r),
        .out_tag   (out_tag)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Sole driver of out_ready: directed level or random stalls.
    always @(posedge clk) begin
        #2;
        if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
        else          out_ready = ready_dir;
    end

    task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    function automatic logic [255:0] model(input logic [63:0] q, input logic m);
        logic [255:0] c;
        c = m ? 256'(MOD1) : 256'(MOD0);
        return 256'(q) * c;
    endfunction

    // Monitor: every real output handshake must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && !flush && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output r=%h tag=%h", out_r, out_tag);
            end else begin
                exp_t e;
                e = sb.pop_front();
                popped++;
                chk("result_r", out_r, e.r);
                chk("result_tag", 256'(out_tag), 256'(e.tag));
            end
        end
    end

    // Drive one operand until accepted; call just after a rising edge.
    task automatic send(input logic [63:0] q, input logic m, input logic [7:0] t,
                        input logic [255:0] exp, input bit push, output int acc_cyc);
        bit done;
        done    = 1'b0;
        acc_cyc = -1;
        in_valid = 1'b1;
        in_q     = q;
        in_mode  = m;
        in_tag   = t;
        for (int n = 0; n < 200 && !done; n++) begin
            @(negedge clk);
            if (in_ready) begin
                if (push) begin
                    exp_t e;
                    e.r   = exp;
                    e.tag = t;
                    sb.push_back(e);
                    pushed++;
                end
                @(posedge clk);
                #1;
                acc_cyc = cyc;
                done    = 1'b1;
            end
        end
        in_valid = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout got=not_accepted exp=accepted");
        end
    endtask

    // Cycles from accept edge to first out_valid; returns at a falling edge.
    task automatic wait_valid(input int acc_cyc, output int lat);
        bit done;
        done = 1'b0;
        lat  = -1;
        for (int n = 0; n < 50 && !done; n++) begin
            @(negedge clk);
            if (out_valid) begin
                lat  = cyc - acc_cyc;
                done = 1'b1;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL valid_timeout got=no_out_valid exp=out_valid");
        end
    endtask

    task automatic drain();
        for (int n = 0; n < 3000 && sb.size() > 0; n++) @(negedge clk);
        chk("scoreboard_empty", 256'(sb.size()), 256'(0));
    endtask

    // out_valid must stay low for a window of cycles.
    task automatic quiet(input string name, input int ncyc);
        int seen;
        seen = 0;
        for (int n = 0; n < ncyc; n++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk(name, 256'(seen), 256'(0));
    endtask

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int a;
        int a2;
        int lat;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_out_valid_low", 256'(out_valid), 256'(0));
        chk("reset_out_r", out_r, 256'(0));
        chk("reset_out_tag", 256'(out_tag), 256'(0));
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_in_ready", 256'(in_ready), 256'(1));

        // Basic: q=1 gives MOD0 zero-extended, 4-cycle latency.
        edge1();
        ready_dir = 1'b1;
        edge1();
        send(64'd1, 1'b0, 8'h5A, {64'd0, MOD0}, 1'b1, a);
        wait_valid(a, lat);
        chk("latency_q1", 256'(lat), 256'(4));
        drain();

        // All-ones operand with MOD1, then zero operand.
        edge1();
        send(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 8'h11,
             (256'(MOD1) << 64) - 256'(MOD1), 1'b1, a);
        send(64'd0, 1'b0, 8'h22, 256'd0, 1'b1, a);
        drain();

        // Continuous traffic: one accept every NLIMB+1 cycles.
        edge1();
        send(64'h0123_4567_89AB_CDEF, 1'b0, 8'h31, model(64'h0123_4567_89AB_CDEF, 1'b0), 1'b1, a);
        send(64'h8000_0000_0000_0001, 1'b1, 8'h32, model(64'h8000_0000_0000_0001, 1'b1), 1'b1, a2);
        chk("b2b_accept_spacing", 256'(a2 - a), 256'(5));
        drain();

        // Backpressure: result and tag held, in_ready low.
        edge1();
        ready_dir = 1'b0;
        edge1();
        send(64'h1234, 1'b0, 8'h33, 256'(64'h1234) * 256'(MOD0), 1'b1, a);
        wait_valid(a, lat);
        chk("latency_bp", 256'(lat), 256'(4));
        for (int i = 0; i < 10; i++) begin
            chk("bp_out_valid", 256'(out_valid), 256'(1));
            chk("bp_out_r", out_r, 256'(64'h1234) * 256'(MOD0));
            chk("bp_out_tag", 256'(out_tag), 256'(8'h33));
            chk("bp_in_ready", 256'(in_ready), 256'(0));
            @(negedge clk);
        end
        edge1();
        ready_dir = 1'b1;
        send(64'd2, 1'b1, 8'h44, {63'd0, MOD1, 1'b0}, 1'b1, a);
        wait_valid(a, lat);
        chk("latency_after_release", 256'(lat), 256'(4));
        drain();

        // in_mode toggling during BUSY is ignored.
        edge1();
        send(64'd3, 1'b0, 8'h55, 256'(MOD0) + 256'(MOD0) + 256'(MOD0), 1'b1, a);
        for (int i = 0; i < 6; i++) begin
            in_mode = ~in_mode;
            edge1();
        end
        send(64'hFFFF_0000_0001_0002, 1'b1, 8'h56, model(64'hFFFF_0000_0001_0002, 1'b1), 1'b1, a);
        for (int i = 0; i < 6; i++) begin
            in_mode = ~in_mode;
            edge1();
        end
        drain();

        // Random traffic with random gaps and output stalls.
        rand_rdy = 1'b1;
        for (int i = 0; i < 200; i++) begin
            logic [63:0] q;
            logic        m;
            logic [7:0]  t;
            q = {$urandom, $urandom};
            m = 1'($urandom_range(0, 1));
            t = 8'($urandom);
            repeat ($urandom_range(0, 2)) edge1();
            send(q, m, t, model(q, m), 1'b1, a);
        end
        rand_rdy  = 1'b0;
        ready_dir = 1'b1;
        drain();
        chk("rand_count", 256'(popped), 256'(pushed));

        // Flush during the second BUSY cycle; a same-cycle in_valid is refused.
        edge1();
        ready_dir = 1'b0;
        edge1();
        send(64'd7, 1'b0, 8'h66, 256'd0, 1'b0, a);
        edge1();
        flush    = 1'b1;
        in_valid = 1'b1;
        in_q     = 64'd9;
        @(negedge clk);
        chk("flush_busy_in_ready", 256'(in_ready), 256'(0));
        edge1();
        flush    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("flush_busy_out_valid", 256'(out_valid), 256'(0));
        chk("flush_busy_idle", 256'(in_ready), 256'(1));
        quiet("flush_busy_quiet", 8);

        // Flush while a result is waiting in DONE.
        edge1();
        send(64'd11, 1'b1, 8'h67, 256'd0, 1'b0, a);
        wait_valid(a, lat);
        edge1();
        flush     = 1'b1;
        in_valid  = 1'b1;
        ready_dir = 1'b1;
        @(negedge clk);
        chk("flush_done_in_ready", 256'(in_ready), 256'(0));
        edge1();
        flush     = 1'b0;
        in_valid  = 1'b0;
        ready_dir = 1'b0;
        @(negedge clk);
        chk("flush_done_out_valid", 256'(out_valid), 256'(0));
        chk("flush_done_idle", 256'(in_ready), 256'(1));
        quiet("flush_done_quiet", 8);

        // Asynchronous reset mid-BUSY clears outputs at once.
        edge1();
        ready_dir = 1'b1;
        send(64'd13, 1'b0, 8'h68, 256'd0, 1'b0, a);
        edge1();
        edge1();
        rst_n = 1'b0;
        #1;
        chk("rst_busy_out_valid", 256'(out_valid), 256'(0));
        chk("rst_busy_out_r", out_r, 256'(0));
        chk("rst_busy_out_tag", 256'(out_tag), 256'(0));
        @(negedge clk);
        rst_n = 1'b1;
        quiet("rst_busy_quiet", 8);

        // Normal operation resumes after reset.
        edge1();
        send(64'd5, 1'b1, 8'h77, model(64'd5, 1'b1), 1'b1, a);
        wait_valid(a, lat);
        chk("latency_post_reset", 256'(lat), 256'(4));
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/xm_iter.md
Name: xm_iter

Overview:
- Parametrised, iterative successor to the fixed 64-bit constant multiplier.
- Computes r = q × MOD[mode] for one of two compile-time moduli, selected per transaction.
- Processes q one limb per cycle, so a wide constant multiply fits a narrow DSP budget.
- Sits between the NTT/MSM operand path and the reduction stage; uses a valid/ready handshake and a tag passthrough.

Parameters:
- Q_W, 64, operand width; must be a multiple of LIMB_W.
- LIMB_W, 16, limb width multiplied per cycle.
- C_W, 192, modulus constant width.
- MOD0, 192'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFFFF_FFFFFFFF, constant selected by mode=0.
- MOD1, 192'hFFFFFFFF_FFFFFFFF_FFFFFFFF_99DEF836_146BC9B1_B4D22831, constant selected by mode=1.
- TAG_W, 8, sideband tag width.
- Derived: NLIMB = Q_W/LIMB_W (4); R_W = Q_W+C_W (256).

Ports:
- clk, in, 1, clock.
- rst_n, in, 1, asynchronous active-low reset.
- flush, in, 1, synchronous abort; returns the block to IDLE.
- in_valid, in, 1, operand valid.
- in_ready, out, 1, block can accept an operand.
- in_q, in, Q_W, operand.
- in_mode, in, 1, modulus select.
- in_tag, in, TAG_W, sideband carried to the output.
- out_valid, out, 1, result valid.
- out_ready, in, 1, downstream accepts the result.
- out_r, out, R_W, product q×MOD.
- out_tag, out, TAG_W, tag of the result.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; out_valid=0; out_r=0; out_tag=0; accumulator, limb counter, operand and mode registers all 0. in_ready is 1 after reset.
- FSM states:
  - IDLE: in_ready=1. On in_valid&&in_ready, latch q, mode and tag; clear acc; cnt=0; go to BUSY.
  - BUSY: in_ready=0. Each cycle: acc <= (acc<<LIMB_W) + limb × MOD[mode], where limb = q[Q_W-1-cnt*LIMB_W -: LIMB_W] (MSB-first); cnt++. When cnt==NLIMB-1, write the final acc value to out_r, set out_valid=1, go to DONE.
  - DONE: out_valid=1; out_r and out_tag held stable until out_valid&&out_ready. in_ready=out_ready. On handshake with in_valid also high, accept the new operand the same cycle and go to BUSY (back-to-back). Without in_valid, go to IDLE and drop out_valid next cycle.
- Latency: out_valid rises exactly NLIMB cycles after the accept edge (4 at defaults).
- Throughput: one result per NLIMB+1 cycles under continuous traffic.
- Arithmetic:
  - acc is R_W bits wide and unsigned.
  - Per-limb product width is LIMB_W+C_W; the sum never exceeds R_W, so no truncation occurs.
  - out_r equals the exact product.
- mode and the constant select are sampled only at accept; in_mode changing during BUSY has no effect.
- flush: highest synchronous priority. From any state, go to IDLE with out_valid=0 next cycle. An in_valid in the same cycle is not accepted: in_ready is forced 0 while flush=1.
- Reset mid-BUSY or mid-DONE: the result is discarded; no stale out_valid after release.
- out_valid must never fall without a handshake, except on flush or reset.
- in_q=0 or MOD=0 needs no special case; the result is 0.

Decomposition:
- Package xm_pkg holds:
  - the state enum {IDLE, BUSY, DONE};
  - default MOD0/MOD1 constants;
  - a function for R_W/NLIMB derivation;
  - an elaboration check that Q_W % LIMB_W == 0.
- Sub-module xm_limb_mac: combinational LIMB_W×C_W multiply plus shifted accumulate add, taking acc, limb and const. It is the single place where the DSP mapping is targeted.
- FSM, handshake and registers stay in xm_iter.

Test Plan:
- Reset, then in_q=1, mode=0, tag=8'h5A, out_ready=1 -> out_valid exactly 4 cycles after accept, out_r=MOD0 zero-extended to 256 bits, out_tag=8'h5A.
- in_q=64'hFFFF_FFFF_FFFF_FFFF, mode=1 -> out_r = (MOD1<<64) − MOD1. Then in_q=0, mode=0 -> out_r=0.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> out_r/out_tag stable and in_ready=0. Release with in_valid high -> same-cycle accept, next result 4 cycles later.
- 200 random (q, mode, tag) with random in_valid/out_ready stalls -> scoreboard matches q×MOD[mode] in order; no drops or duplicates.
- Toggle in_mode every cycle during BUSY -> result uses the mode latched at accept.
- flush asserted during cycle 2 of BUSY, and separately during DONE -> out_valid 0 next cycle, state IDLE, in_ready=1 the cycle after flush deasserts. rst_n pulsed low mid-BUSY -> all outputs 0 immediately, no spurious out_valid after release.
